// File: rtl/prio_enc_disp.sv
// Registered priority encoder with synchroniser, debounce FSM, hex 7-seg readout
// and a valid/ready change-event port with sticky overwrite flag.
module prio_enc_disp #(
    parameter int unsigned N_IN         = 16,
    parameter int unsigned DIGITS       = 2,
    parameter int unsigned DEBOUNCE_CYC = 4,
    localparam int unsigned W_IDX       = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN-1:0]       x,
    input  logic                  en,
    output logic [W_IDX-1:0]      idx,
    output logic                  ind,
    output logic [8*DIGITS-1:0]   seg,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [W_IDX-1:0]      evt_idx,
    output logic                  evt_ind,
    output logic                  evt_ovf,
    input  logic                  ovf_clr
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_COUNT  = 2'd1;
    localparam logic [1:0]  ST_COMMIT = 2'd2;
    localparam logic [15:0] DB_CNT    = 16'(DEBOUNCE_CYC);

    logic [N_IN:0]          r_sync1;
    logic [N_IN:0]          r_sync2;
    logic [N_IN:0]          r_cand;
    logic [N_IN:0]          r_com;
    logic [1:0]             r_state;
    logic [15:0]            r_cnt;

    logic [W_IDX-1:0]       r_idx;
    logic                   r_ind;
    logic [8*DIGITS-1:0]    r_seg;
    logic                   r_evt_valid;
    logic [W_IDX-1:0]       r_evt_idx;
    logic                   r_evt_ind;
    logic                   r_evt_ovf;

    logic [W_IDX-1:0]       w_new_idx;
    logic                   w_new_ind;
    logic [8*DIGITS-1:0]    w_new_seg;
    logic [4*DIGITS-1:0]    w_idx_ext;
    logic                   w_commit;
    logic                   w_change;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        // a..g, active-low
        case (n)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    // Encode from the candidate so outputs load on the same edge the FSM commits.
    always_comb begin
        w_new_ind = r_cand[N_IN] & (|r_cand[N_IN-1:0]);
        w_new_idx = '0;
        if (w_new_ind) begin
            for (int i = 0; i < int'(N_IN); i++) begin
                if (r_cand[i]) w_new_idx = W_IDX'(i);
            end
        end
    end

    always_comb begin
        w_idx_ext = '0;
        w_idx_ext[W_IDX-1:0] = w_new_idx;
        w_new_seg = '1;
        if (w_new_ind) begin
            for (int d = 0; d < int'(DIGITS); d++) begin
                w_new_seg[8*d+1 +: 7] = hex7(w_idx_ext[4*d +: 4]);
            end
            w_new_seg[0] = 1'b0;
        end
    end

    assign w_commit = (r_state == ST_COMMIT);
    assign w_change = w_commit && ({w_new_idx, w_new_ind} != {r_idx, r_ind});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {en, x};
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_com   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_sync2 != r_com) begin
                        r_cand  <= r_sync2;
                        r_cnt   <= 16'd1;
                        r_state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (r_sync2 != r_cand) begin
                        r_cand <= r_sync2;
                        r_cnt  <= 16'd1;
                    end else if (r_sync2 == r_com) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == DB_CNT) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_COMMIT: begin
                    r_com   <= r_cand;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
            r_ind <= 1'b0;
            r_seg <= '1;
        end else if (w_commit) begin
            r_idx <= w_new_idx;
            r_ind <= w_new_ind;
            r_seg <= w_new_seg;
        end
    end

    // A new change always lands in the event slot; overflow only if the old one was lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_evt_valid <= 1'b0;
            r_evt_idx   <= '0;
            r_evt_ind   <= 1'b0;
            r_evt_ovf   <= 1'b0;
        end else begin
            if (w_change) begin
                r_evt_valid <= 1'b1;
                r_evt_idx   <= w_new_idx;
                r_evt_ind   <= w_new_ind;
            end else if (r_evt_valid && evt_ready) begin
                r_evt_valid <= 1'b0;
            end
            if (w_change && r_evt_valid && !evt_ready) begin
                r_evt_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_evt_ovf <= 1'b0;
            end
        end
    end

    assign idx       = r_idx;
    assign ind       = r_ind;
    assign seg       = r_seg;
    assign evt_valid = r_evt_valid;
    assign evt_idx   = r_evt_idx;
    assign evt_ind   = r_evt_ind;
    assign evt_ovf   = r_evt_ovf;

endmodule

// File: tb/tb_prio_enc_disp.sv
// Directed, table-driven self-checking bench for prio_enc_disp (N_IN=16, DIGITS=2).
module tb_prio_enc_disp;

    logic        clk;
    logic        rst;
    logic [15:0] x;
    logic        en;
    logic [3:0]  idx;
    logic        ind;
    logic [15:0] seg;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_idx;
    logic        evt_ind;
    logic        evt_ovf;
    logic        ovf_clr;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic        en;
        logic [15:0] x;
        logic [3:0]  idx;
        logic        ind;
        logic [15:0] seg;
    } vec_t;

    vec_t vecs[18];

    prio_enc_disp #(
        .N_IN        (16),
        .DIGITS      (2),
        .DEBOUNCE_CYC(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .en       (en),
        .idx      (idx),
        .ind      (ind),
        .seg      (seg),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_idx  (evt_idx),
        .evt_ind  (evt_ind),
        .evt_ovf  (evt_ovf),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_idx, input logic e_ind,
                           input logic [15:0] e_seg);
        chk({tag, "_idx"}, 32'(idx), 32'(e_idx));
        chk({tag, "_ind"}, 32'(ind), 32'(e_ind));
        chk({tag, "_seg"}, 32'(seg), 32'(e_seg));
    endtask

    task automatic chk_reset(input string tag);
        chk_out(tag, 4'd0, 1'b0, 16'hFFFF);
        chk({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
        chk({tag, "_evt_idx"}, 32'(evt_idx), 32'd0);
        chk({tag, "_evt_ind"}, 32'(evt_ind), 32'd0);
        chk({tag, "_evt_ovf"}, 32'(evt_ovf), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        vecs[0]  = '{1'b1, 16'h0090, 4'd7,  1'b1, 16'h031E};
        vecs[1]  = '{1'b1, 16'h0000, 4'd0,  1'b0, 16'hFFFF};
        vecs[2]  = '{1'b1, 16'h0C30, 4'd11, 1'b1, 16'h03C0};
        vecs[3]  = '{1'b0, 16'h1234, 4'd0,  1'b0, 16'hFFFF};
        vecs[4]  = '{1'b1, 16'h2001, 4'd13, 1'b1, 16'h0384};
        vecs[5]  = '{1'b1, 16'h0024, 4'd5,  1'b1, 16'h0348};
        vecs[6]  = '{1'b1, 16'h0100, 4'd8,  1'b1, 16'h0300};
        vecs[7]  = '{1'b1, 16'h4000, 4'd14, 1'b1, 16'h0360};
        vecs[8]  = '{1'b1, 16'h0200, 4'd9,  1'b1, 16'h0308};
        vecs[9]  = '{1'b1, 16'h0008, 4'd3,  1'b1, 16'h030C};
        vecs[10] = '{1'b1, 16'h0004, 4'd2,  1'b1, 16'h0324};
        vecs[11] = '{1'b1, 16'h0002, 4'd1,  1'b1, 16'h039E};
        vecs[12] = '{1'b1, 16'h0010, 4'd4,  1'b1, 16'h0398};
        vecs[13] = '{1'b1, 16'h0040, 4'd6,  1'b1, 16'h0340};
        vecs[14] = '{1'b1, 16'h1000, 4'd12, 1'b1, 16'h0362};
        vecs[15] = '{1'b1, 16'h0400, 4'd10, 1'b1, 16'h0310};
        vecs[16] = '{1'b1, 16'h0001, 4'd0,  1'b1, 16'h0302};
        vecs[17] = '{1'b1, 16'h8000, 4'd15, 1'b1, 16'h0370};

        // Reset
        rst = 1'b0; x = '0; en = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk_reset("reset");

        // First commit and its fixed latency
        en = 1'b1; x = 16'h0090;
        tick(7);
        chk("lat_early_idx", 32'(idx), 32'd0);
        chk("lat_early_valid", 32'(evt_valid), 32'd0);
        tick(1);
        chk_out("first", 4'd7, 1'b1, 16'h031E);
        chk("first_evt_valid", 32'(evt_valid), 32'd1);
        chk("first_evt_idx", 32'(evt_idx), 32'd7);
        chk("first_evt_ind", 32'(evt_ind), 32'd1);

        // Short glitch bounces back: no commit, no new event
        x = 16'h8000;
        tick(2);
        x = 16'h0090;
        tick(10);
        chk("glitch_idx", 32'(idx), 32'd7);
        chk("glitch_evt_idx", 32'(evt_idx), 32'd7);
        chk("glitch_evt_ovf", 32'(evt_ovf), 32'd0);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("drain1_valid", 32'(evt_valid), 32'd0);

        // Overwrite while pending sets ovf; ovf_clr clears it
        x = 16'h0001;
        tick(8);
        chk("ovf_a_idx", 32'(evt_idx), 32'd0);
        chk("ovf_a_ovf", 32'(evt_ovf), 32'd0);
        x = 16'h0400;
        tick(8);
        chk("ovf_b_evt_idx", 32'(evt_idx), 32'd10);
        chk("ovf_b_ovf", 32'(evt_ovf), 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_clr_ovf", 32'(evt_ovf), 32'd0);
        chk("ovf_clr_valid", 32'(evt_valid), 32'd1);

        // Accept on the same edge as a new commit: reload, no overflow
        x = 16'h0090;
        tick(7);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("same_valid", 32'(evt_valid), 32'd1);
        chk("same_evt_idx", 32'(evt_idx), 32'd7);
        chk("same_ovf", 32'(evt_ovf), 32'd0);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("drain2_valid", 32'(evt_valid), 32'd0);

        // Overflow set wins over a same-edge ovf_clr
        x = 16'h0001;
        tick(8);
        x = 16'h8000;
        tick(7);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovfprio_ovf", 32'(evt_ovf), 32'd1);
        chk("ovfprio_evt_idx", 32'(evt_idx), 32'd15);
        ovf_clr = 1'b1; evt_ready = 1'b1;
        tick(1);
        ovf_clr = 1'b0; evt_ready = 1'b0;
        chk("ovfprio_clr", 32'(evt_ovf), 32'd0);

        // Table of encoder/display vectors, events accepted immediately
        evt_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            en = vecs[i].en;
            x  = vecs[i].x;
            tick(8);
            chk_out($sformatf("tbl%0d", i), vecs[i].idx, vecs[i].ind, vecs[i].seg);
            chk($sformatf("tbl%0d_evt_valid", i), 32'(evt_valid), 32'd1);
            chk($sformatf("tbl%0d_evt_idx", i), 32'(evt_idx), 32'(vecs[i].idx));
            chk($sformatf("tbl%0d_evt_ind", i), 32'(evt_ind), 32'(vecs[i].ind));
            tick(1);
        end
        evt_ready = 1'b0;

        // Disabled with all bits set -> blank
        en = 1'b0; x = 16'hFFFF;
        tick(8);
        chk_out("dis", 4'd0, 1'b0, 16'hFFFF);

        // Reset mid-COUNT with an event pending
        en = 1'b1; x = 16'h0090;
        tick(4);
        rst = 1'b0;
        #1;
        chk_reset("rst_async");
        tick(1);
        chk_reset("rst_next");
        rst = 1'b1;
        tick(2);
        chk_reset("rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
